// File: rtl/jk_counter.sv
// Reversible, loadable counter built from WIDTH JK stages with registered true/complement outputs.
// Define JK_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module jk_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             wrap
);

  typedef enum logic [1:0] {ModeHold, ModeUp, ModeDown, ModeLoad} mode_e;

  logic [WIDTH-1:0] q_q, q_bar_q, q_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] lo_mask;
  logic             wrap_q, wrap_d;

  // Stage i toggles when every lower stage is 1 (up) or every lower complement is 1 (down).
  always_comb begin
    lo_mask = '0;
    up_t    = '0;
    dn_t    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lo_mask = (WIDTH'(1) << i) - WIDTH'(1);
      up_t[i] = ((q_q & lo_mask) == lo_mask);
      dn_t[i] = ((q_bar_q & lo_mask) == lo_mask);
    end
  end

  always_comb begin
    j      = '0;
    k      = '0;
    wrap_d = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        ModeHold: begin
          j = '0;
          k = '0;
        end
        ModeUp: begin
          j      = up_t;
          k      = up_t;
          wrap_d = &q_q;
`ifdef JK_COUNTER_SAT_EN
          if (&q_q) begin
            j = '0;
            k = '0;
          end
`endif
        end
        ModeDown: begin
          j      = dn_t;
          k      = dn_t;
          wrap_d = &q_bar_q;
`ifdef JK_COUNTER_SAT_EN
          if (&q_bar_q) begin
            j = '0;
            k = '0;
          end
`endif
        end
        ModeLoad: begin
          j = load_val;
          k = ~load_val;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  // Standard JK characteristic per stage.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({j[i], k[i]})
        2'b00:   q_d[i] = q_q[i];
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        2'b11:   q_d[i] = ~q_q[i];
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= RST_VAL;
      q_bar_q <= ~RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      q_bar_q <= ~q_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = q_bar_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_jk_counter.sv
// Directed and model-checked bench for jk_counter (WIDTH=4, RST_VAL=4'hA) plus a WIDTH=2 instance.
module tb_jk_counter;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] load_val;
  logic [3:0] q, q_bar;
  logic       wrap;

  logic       rst2, en2;
  logic [1:0] mode2;
  logic [1:0] load_val2;
  logic [1:0] q2, q_bar2;
  logic       wrap2;

  int n_cmp = 0;
  int n_bad = 0;
  bit inv_on = 1'b0;

  always #5 clk = ~clk;

  jk_counter #(.WIDTH(4), .RST_VAL(4'hA)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
    .Q(q), .Q_bar(q_bar), .wrap(wrap)
  );

  jk_counter #(.WIDTH(2), .RST_VAL(2'd3)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .load_val(load_val2),
    .Q(q2), .Q_bar(q_bar2), .wrap(wrap2)
  );

  // Complement invariant, checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (inv_on) begin
      n_cmp++;
      if (q_bar !== ~q) begin
        n_bad++;
        $display("FAIL inv_qbar: Q=%h Q_bar=%h required Q_bar=%h", q, q_bar, ~q);
      end
      n_cmp++;
      if (q_bar2 !== ~q2) begin
        n_bad++;
        $display("FAIL inv_qbar2: Q=%h Q_bar=%h required Q_bar=%h", q2, q_bar2, ~q2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] eq, input logic ew);
    n_cmp++;
    if (q !== eq || wrap !== ew) begin
      n_bad++;
      $display("FAIL %s: Q=%h wrap=%b required Q=%h wrap=%b", name, q, wrap, eq, ew);
    end
  endtask

  task automatic load(input logic [3:0] v);
    en = 1'b1; mode = 2'b11; load_val = v;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; load_val = 4'h0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 2'b00; load_val2 = 2'd0;
    tick();
    tick();
    inv_on = 1'b1;
    n_cmp++;
    if (q !== 4'hA || q_bar !== 4'h5 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: Q=%h Q_bar=%h wrap=%b required Q=a Q_bar=5 wrap=0", q, q_bar, wrap);
    end
    rst = 1'b0; en = 1'b1; mode = 2'b01;
    tick();
    chk("reset_first_up", 4'hB, 1'b0);
  endtask

  task automatic test_up_wrap();
    logic [3:0] eq [3];
    logic       ew [3];
`ifdef JK_COUNTER_SAT_EN
    eq = '{4'hF, 4'hF, 4'hF}; ew = '{1'b0, 1'b1, 1'b1};
`else
    eq = '{4'hF, 4'h0, 4'h1}; ew = '{1'b0, 1'b1, 1'b0};
`endif
    load(4'hE);
    chk("up_load", 4'hE, 1'b0);
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("up_wrap_%0d", i), eq[i], ew[i]);
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] eq [3];
    logic       ew [3];
`ifdef JK_COUNTER_SAT_EN
    eq = '{4'h0, 4'h0, 4'h0}; ew = '{1'b0, 1'b1, 1'b1};
`else
    eq = '{4'h0, 4'hF, 4'hE}; ew = '{1'b0, 1'b1, 1'b0};
`endif
    load(4'h1);
    mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("down_wrap_%0d", i), eq[i], ew[i]);
    end
  endtask

  task automatic test_hold();
    load(4'h7);
    en = 1'b0; mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en_off_%0d", i), 4'h7, 1'b0);
    end
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mode_hold_%0d", i), 4'h7, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    load(4'hF);
    mode = 2'b01; rst = 1'b1;
    tick();
    chk("reset_mid", 4'hA, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_load();
    load(4'hF);
    chk("load_ff", 4'hF, 1'b0);
    load(4'h0);
    chk("load_0_from_f", 4'h0, 1'b0);
    mode = 2'b10;
    tick();
`ifdef JK_COUNTER_SAT_EN
    chk("down_from_0", 4'h0, 1'b1);
`else
    chk("down_from_0", 4'hF, 1'b1);
`endif
    load(4'h0);
    mode = 2'b01;
    tick();
    chk("switch_up", 4'h1, 1'b0);
    mode = 2'b10;
    tick();
    chk("switch_down", 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0; en2 = 1'b1; mode2 = 2'b01;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] eq2;
      logic       ew2;
`ifdef JK_COUNTER_SAT_EN
      eq2 = 2'd3; ew2 = 1'b1;
`else
      eq2 = 2'(i); ew2 = (i % 4 == 0);
`endif
      tick();
      n_cmp++;
      if (q2 !== eq2 || wrap2 !== ew2) begin
        n_bad++;
        $display("FAIL b2b_%0d: Q=%h wrap=%b required Q=%h wrap=%b", i, q2, wrap2, eq2, ew2);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic       mw;
    rst = 1'b1;
    tick();
    m = 4'hA; mw = 1'b0;
    chk("rand_start", m, mw);
    for (int c = 0; c < 1000; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      load_val = 4'($urandom_range(0, 15));
      mw = 1'b0;
      if (rst) begin
        m = 4'hA;
      end else if (en) begin
        case (mode)
          2'b01: begin
            if (m == 4'hF) begin
              mw = 1'b1;
`ifndef JK_COUNTER_SAT_EN
              m = 4'h0;
`endif
            end else m = m + 4'h1;
          end
          2'b10: begin
            if (m == 4'h0) begin
              mw = 1'b1;
`ifndef JK_COUNTER_SAT_EN
              m = 4'hF;
`endif
            end else m = m - 4'h1;
          end
          2'b11: m = load_val;
          default: m = m;
        endcase
      end
      tick();
      chk($sformatf("rand_%0d", c), m, mw);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_hold();
    test_reset_mid();
    test_load();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_counter.md
# jk_counter

Parametrised synchronous up/down counter built from WIDTH JK flip-flop stages. Per-stage J/K inputs derive from the selected mode (hold, count up, count down, parallel load). True and complementary outputs are registered and always consistent. It sits beside the single-bit JK flip-flop in the sequential-element library and is used wherever a loadable, reversible count with a wrap indication is needed.

## Interface
- WIDTH, 4: number of JK stages / counter bits; legal values 2..32.
- RST_VAL, 0: value loaded into Q on reset; WIDTH bits, zero-extended/truncated.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous to clk, active-high.
- en  input  1  stage update enable; 0 freezes all state (J=K=0 on every stage).
- mode  input  2  00 hold, 01 count up, 10 count down, 11 parallel load.
- load_val  input  WIDTH  value captured when mode=11 and en=1.
- Q  output  WIDTH  counter state.
- Q_bar  output  WIDTH  bitwise complement of Q; registered, never derived combinationally.
- wrap  output  1  one-cycle pulse after a count crossed the range boundary.

## Operation
- Each bit i is a JK stage with the standard rules: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle. Q_bar[i] is updated with the complement value in the same edge.
- Stage inputs per mode, when en=1:
  - 00: J=K=0 for all i.
  - 01: J_i=K_i=AND(Q[i-1:0]); bit 0 has J=K=1.
  - 10: J_i=K_i=AND(Q_bar[i-1:0]); bit 0 has J=K=1.
  - 11: J_i=load_val[i], K_i=~load_val[i].
- When en=0, J=K=0 on all stages regardless of mode. wrap is cleared.
- Arithmetic is modulo 2^WIDTH.
  - Up from all-ones goes to 0.
  - Down from 0 goes to all-ones.
- wrap is set for exactly one cycle when the edge performed an up-count from all-ones or a down-count from 0. Otherwise it is 0, including for load and hold.
- Load of any value, including all-ones or 0, never sets wrap.
- Invariant: Q_bar == ~Q at every clock edge and after reset. A bench assertion checks this every cycle.

## Timing
- All outputs are registered. A change on en, mode or load_val is visible on Q, Q_bar and wrap after the next rising edge (1-cycle latency).
- Reset: on a rising edge with rst=1, the block sets Q=RST_VAL, Q_bar=~RST_VAL and wrap=0.
  - rst has priority over en and mode.
  - rst asserted mid-count aborts the count at that edge, with no wrap pulse.
- First edge after rst deasserts: normal operation using the current en and mode.
- Back-to-back wraps are possible. With WIDTH=2, up-counting from 3 gives wrap pulses spaced 4 cycles apart.
- A mode change between up and down takes effect on the next edge with no dead cycle. Example: Q=0, mode switches 01->10, Q goes to all-ones and wrap=1.

## Configuration
- JK_COUNTER_SAT_EN defined: the counter saturates instead of wrapping.
  - Up at all-ones: stages get J=K=0 and Q stays all-ones.
  - Down at 0: stages get J=K=0 and Q stays 0.
  - wrap pulses for one cycle on each edge where a count was blocked by saturation.
- JK_COUNTER_SAT_EN undefined: modulo wrap as described under Operation.
- Load, hold, en and reset behaviour are identical in both builds.

## Test plan
- Reset: WIDTH=4, RST_VAL=4'hA, rst=1 for 2 cycles -> Q=4'hA, Q_bar=4'h5, wrap=0. Then en=1, mode=01 -> Q=4'hB after 1 edge.
- Up wrap: WIDTH=4, load 4'hE, then mode=01 for 3 edges -> Q=F,0,1. wrap=1 only in the cycle Q=0. In the saturating build: Q=F,F,F, with wrap=1 on the 2nd and 3rd edges.
- Down wrap: load 4'h1, mode=10 for 3 edges -> Q=0,F,E. wrap=1 only in the cycle Q=F.
- Enable/hold: Q=4'h7, en=0 with mode=01 for 5 edges, then en=1 with mode=00 for 2 edges -> Q stays 7, wrap=0 throughout.
- Reset mid-count: counting up at Q=4'hF, rst=1 on the wrapping edge -> Q=RST_VAL, wrap=0. The Q_bar==~Q assertion holds every cycle.
- Load priority: mode=11, load_val=4'h0, applied while Q=4'hF -> Q=0, wrap=0. A random mode/en/load sequence of 1000 cycles matches a reference model.
